uart_rx_deframer: RTL and testbench

Receive-side line deframer for the UART peripheral. It synchronises the asynchronous `rx` pin, detects start bits, and oversamples at 16 ticks per bit driven by the UART's `main_clk` enable. It reassembles 5–8 data bits with optional parity and 1 or 2 stop bits, and presents each received character with error flags as a one-cycle write strobe. The block sits between the `rx` pin and the RX FIFO: `data_out` feeds the FIFO `di` input and `data_valid` drives its `we`.

---
 rtl/uart_rx_deframer.sv | 150 +++++++++++++++
 tb/tb_uart_rx_deframer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises rxd, oversamples 16x per bit and delivers
// each character (5-8 data bits, optional parity, 1/2 stop bits) as a one-cycle strobe.
module uart_rx_deframer #(
  parameter int SYNC_STAGES = 2,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       rxd,
  input  logic [1:0] data_bits_count,
  input  logic [1:0] parity_type,
  input  logic       double_stop_bits,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_IDLE} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [3:0]             cnt, cnt_n;
  logic [2:0]             bit_cnt, bit_cnt_n;
  logic [7:0]             shift_q, shift_n;
  logic [1:0]             cfg_bits, cfg_bits_n;
  logic [1:0]             cfg_par, cfg_par_n;
  logic                   cfg_stop2, cfg_stop2_n;
  logic                   par_err_q, par_err_n;
  logic                   finish;
  logic                   frame_bad;

  function automatic logic parity_enabled(input logic [1:0] ptype);
    return (ptype == 2'b01) || (ptype == 2'b10);
  endfunction

  // Unused upper shift bits are always 0, so a full-width XOR is safe.
  function automatic logic expected_parity(input logic [7:0] data, input logic [1:0] ptype);
    return (^data) ^ (ptype == 2'b10);
  endfunction

  assign rxs  = sync_q[SYNC_STAGES-1];
  assign busy = (state != IDLE);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift_q;
    cfg_bits_n  = cfg_bits;
    cfg_par_n   = cfg_par;
    cfg_stop2_n = cfg_stop2;
    par_err_n   = par_err_q;
    finish      = 1'b0;
    frame_bad   = 1'b0;
    if (sample_tick) begin
      cnt_n = cnt + 4'd1;
      case (state)
        IDLE: if (!rxs) begin
          cnt_n       = 4'd0;
          bit_cnt_n   = 3'd0;
          shift_n     = 8'h00;
          par_err_n   = 1'b0;
          cfg_bits_n  = data_bits_count;
          cfg_par_n   = parity_type;
          cfg_stop2_n = double_stop_bits;
          state_n     = START;
        end
        START: if (cnt == MID_TICK) begin
          if (rxs) begin
            state_n = IDLE;
          end else begin
            cnt_n   = 4'd0;
            state_n = DATA;
          end
        end
        DATA: if (cnt == LAST_TICK) begin
          shift_n[bit_cnt] = rxs;
          bit_cnt_n        = bit_cnt + 3'd1;
          if (bit_cnt == ({1'b0, cfg_bits} + 3'd4))
            state_n = parity_enabled(cfg_par) ? PARITY : STOP1;
        end
        PARITY: if (cnt == LAST_TICK) begin
          par_err_n = (rxs != expected_parity(shift_q, cfg_par));
          state_n   = STOP1;
        end
        STOP1: if (cnt == LAST_TICK) begin
          if (!rxs) begin
            finish    = 1'b1;
            frame_bad = 1'b1;
            state_n   = WAIT_IDLE;
          end else if (cfg_stop2) begin
            state_n = STOP2;
          end else begin
            finish  = 1'b1;
            state_n = IDLE;
          end
        end
        STOP2: if (cnt == LAST_TICK) begin
          finish    = 1'b1;
          frame_bad = !rxs;
          state_n   = rxs ? IDLE : WAIT_IDLE;
        end
        WAIT_IDLE: if (rxs) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '1;
      state      <= IDLE;
      cnt        <= 4'd0;
      bit_cnt    <= 3'd0;
      shift_q    <= 8'h00;
      cfg_bits   <= 2'd0;
      cfg_par    <= 2'd0;
      cfg_stop2  <= 1'b0;
      par_err_q  <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rxd};
      state      <= state_n;
      cnt        <= cnt_n;
      bit_cnt    <= bit_cnt_n;
      shift_q    <= shift_n;
      cfg_bits   <= cfg_bits_n;
      cfg_par    <= cfg_par_n;
      cfg_stop2  <= cfg_stop2_n;
      par_err_q  <= par_err_n;
      data_valid <= finish;
      if (finish) begin
        data_out   <= shift_q;
        parity_err <= par_err_q;
        frame_err  <= frame_bad;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer: each driven frame pushes its expected
// character and flags; the monitor pops and compares on every data_valid.
module tb_uart_rx_deframer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_tick = 1'b1;
  logic       rxd = 1'b1;
  logic [1:0] data_bits_count = 2'd3;
  logic [1:0] parity_type = 2'd0;
  logic       double_stop_bits = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   tick_div = 1;
  int   div_cnt = 0;

  uart_rx_deframer #(.SYNC_STAGES(2), .OVERSAMPLE(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .sample_tick      (sample_tick),
    .rxd              (rxd),
    .data_bits_count  (data_bits_count),
    .parity_type      (parity_type),
    .double_stop_bits (double_stop_bits),
    .data_out         (data_out),
    .data_valid       (data_valid),
    .parity_err       (parity_err),
    .frame_err        (frame_err),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (div_cnt >= tick_div - 1) begin
      sample_tick = 1'b1;
      div_cnt = 0;
    end else begin
      sample_tick = 1'b0;
      div_cnt = div_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (data_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("data_out", {24'd0, data_out}, {24'd0, e.d});
        check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
        check("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
      end
    end
  end

  // One bit period = 16 sample ticks; rxd changes on the falling clock edge.
  task automatic send_bit(input logic b);
    int n;
    rxd = b;
    n = 0;
    while (n < 16) begin
      @(posedge clk);
      if (sample_tick) n++;
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic [1:0] ptype,
                            input logic stop2, input logic flip_par, input logic stop1_val,
                            input logic chg_cfg, input string tag);
    logic [7:0] dm;
    logic       pen;
    exp_t       e;
    dm = d & 8'((1 << nbits) - 1);
    pen = (ptype == 2'b01) || (ptype == 2'b10);
    data_bits_count = 2'(nbits - 5);
    parity_type = ptype;
    double_stop_bits = stop2;
    e.d = dm;
    e.pe = pen && flip_par;
    e.fe = !stop1_val;
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) begin
      send_bit(dm[i]);
      if (chg_cfg && i == 2) data_bits_count = 2'd0;
    end
    if (pen) send_bit((^dm) ^ (ptype == 2'b10) ^ flip_par);
    send_bit(stop1_val);
    if (stop1_val) begin
      if (stop2) send_bit(1'b1);
      send_bit(1'b1);
      check({tag, "_delivered"}, exp_q.size(), 0);
      check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_flags", {30'd0, parity_err, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    send_bit(1'b1);

    send_frame(8'hA5, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, "8n1_a5");
    send_frame(8'h1B, 5, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, "5e2_ok");
    send_frame(8'h1B, 5, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, "5e2_bad");

    // Partial 0x3C aborted by reset; parity_err from the previous frame must clear.
    data_bits_count = 2'd3;
    parity_type = 2'b00;
    double_stop_bits = 1'b0;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_valid", {31'd0, data_valid}, 32'd0);
    check("midrst_data", {24'd0, data_out}, 32'd0);
    check("midrst_flags", {30'd0, parity_err, frame_err}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    rxd = 1'b1;
    send_bit(1'b1);
    send_frame(8'h3C, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, "after_rst");

    // 7O1 with low stop bit, then line held low for 40 bit times.
    send_frame(8'h5A, 7, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, "7o1_ferr");
    repeat (40) send_bit(1'b0);
    check("hold_low_busy", {31'd0, busy}, 32'd1);
    check("hold_low_nochar", exp_q.size(), 0);
    send_bit(1'b1);
    check("hold_release_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h2D, 7, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, "7o1_next");

    // Glitch: 4 ticks low, then high.
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_started", {31'd0, busy}, 32'd1);
    rxd = 1'b1;
    repeat (32) @(negedge clk);
    check("glitch_idle", {31'd0, busy}, 32'd0);

    send_frame(8'hFF, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, "cfg_change");

    // Slower tick enable: one tick every 3 clocks.
    tick_div = 3;
    send_bit(1'b1);
    send_frame(8'h96, 8, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, "div3_8e2");
    send_frame(8'h29, 6, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, "div3_6o1");

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
